// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage, the instruction field
// decoder and the controller-side logic.
//   fetch_state_t : fetch handshake FSM states
//   *_MSB/*_LSB   : bit positions of every instruction field in the IR
//   OPC_*         : opcode values consumed by the controller
//   sext8/sext5   : sign extension of the immediate fields
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int OP_MSB    = 12;
  localparam int OP_LSB    = 11;
  localparam int RN_MSB    = 10;
  localparam int RN_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int SH_MSB    = 4;
  localparam int SH_LSB    = 3;
  localparam int RM_MSB    = 2;
  localparam int RM_LSB    = 0;
  localparam int IMM8_MSB  = 7;
  localparam int IMM8_LSB  = 0;
  localparam int IMM5_MSB  = 4;
  localparam int IMM5_LSB  = 0;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_BR  = 3'b001;

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic signed [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
//   mem_req   : read request, held until ack or abort
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : read data valid this cycle
//   mem_rdata : 16-bit instruction word
// master = fetch stage, slave = memory.
interface instr_fetch_decode_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [15:0]     mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 16-bit instruction into its fields.
//   ir              : instruction register contents
//   opcode/op       : fields consumed by the controller
//   rn/rd/rm/shift  : register indices and shift control for the datapath
//   sximm8/sximm5   : sign-extended immediates
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [15:0]        ir,
  output logic [2:0]         opcode,
  output logic [1:0]         op,
  output logic [2:0]         rn,
  output logic [2:0]         rd,
  output logic [1:0]         shift,
  output logic [2:0]         rm,
  output logic signed [15:0] sximm8,
  output logic signed [15:0] sximm5
);

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign op     = ir[OP_MSB:OP_LSB];
  assign rn     = ir[RN_MSB:RN_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign shift  = ir[SH_MSB:SH_LSB];
  assign rm     = ir[RM_MSB:RM_LSB];
  assign sximm8 = sext8(ir[IMM8_MSB:IMM8_LSB]);
  assign sximm5 = sext5(ir[IMM5_MSB:IMM5_LSB]);

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch stage feeding the CPU controller.
// Holds the PC and the instruction register. When the controller raises
// load_ir, the current PC is latched as the fetch address and a req/ack read
// is run on the memory bus; a fetch that sees no ack within TIMEOUT+1 request
// cycles is aborted and flagged in the sticky fetch_err. The PC is updated
// from load_pc/choose_pc/br_en on any edge, independent of the fetch.
//   clk, rst_n                         : clock, async active-low reset
//   load_ir                            : fetch request from controller
//   load_pc, choose_pc, br_en, br_target : PC update controls
//   mem (master)                       : instruction-memory read bus
//   pc, ir_valid, fetch_err            : fetch status
//   opcode..sximm5                     : fields decoded from the IR
module instr_fetch_decode
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_ir,
  input  logic                load_pc,
  input  logic                choose_pc,
  input  logic                br_en,
  input  logic [PC_W-1:0]     br_target,
  instr_fetch_decode_if.master mem,
  output logic [PC_W-1:0]     pc,
  output logic                ir_valid,
  output logic                fetch_err,
  output logic [2:0]          opcode,
  output logic [1:0]          op,
  output logic [2:0]          rn,
  output logic [2:0]          rd,
  output logic [1:0]          shift,
  output logic [2:0]          rm,
  output logic signed [15:0]  sximm8,
  output logic signed [15:0]  sximm5
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_addr;
  logic [15:0]     ir;
  logic [7:0]      wait_cnt;

  logic start_fetch;
  logic got_ack;
  logic abort;

  // Acks outside REQ are ignored by construction: every use is qualified.
  assign start_fetch = (state == IDLE) && load_ir;
  assign got_ack     = (state == REQ) && mem.mem_ack;
  assign abort       = (state == REQ) && !mem.mem_ack && (wait_cnt == TIMEOUT_CNT);

  // mem_req comes straight from the state register, so it is glitch-free,
  // rises one cycle after load_ir is sampled and drops at once on reset.
  assign mem.mem_req  = (state == REQ);
  assign mem.mem_addr = fetch_addr;

  // ---- fetch FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (load_ir) state_nxt = REQ;
      REQ: begin
        if (mem.mem_ack)                  state_nxt = DONE;
        else if (wait_cnt == TIMEOUT_CNT) state_nxt = IDLE;
      end
      // A level-held load_ir parks here instead of re-fetching.
      DONE: if (!load_ir) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- fetch datapath: address latch, IR, status, wait counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= RESET_VEC;
      ir         <= 16'h0000;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= 8'd0;
    end else begin
      if (start_fetch) begin
        // Old pc is captured even if load_pc fires on the same edge.
        fetch_addr <= pc;
        ir_valid   <= 1'b0;
        wait_cnt   <= 8'd0;
      end else if (got_ack) begin
        ir       <= mem.mem_rdata;
        ir_valid <= 1'b1;
      end else if (abort) begin
        fetch_err <= 1'b1;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // ---- program counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VEC;
    end else if (load_pc) begin
      if (choose_pc)  pc <= RESET_VEC;
      else if (br_en) pc <= br_target;
      else            pc <= pc + PC_W'(1);
    end
  end

  // ---- field decode from the IR register only ----
  instr_field_decode u_decode (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .shift  (shift),
    .rm     (rm),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: directed scenarios followed by
// randomized fetches with random wait states, timeouts and PC traffic.
module tb_instr_fetch_decode;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 15;
  localparam int RV      = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_ir = 1'b0;
  logic              load_pc = 1'b0;
  logic              choose_pc = 1'b0;
  logic              br_en = 1'b0;
  logic [PC_W-1:0]   br_target = '0;
  logic [PC_W-1:0]   pc;
  logic              ir_valid;
  logic              fetch_err;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [1:0]        shift;
  logic [2:0]        rm;
  logic signed [15:0] sximm8;
  logic signed [15:0] sximm5;

  instr_fetch_decode_if #(.PC_W(PC_W)) bus ();

  instr_fetch_decode #(
    .PC_W      (PC_W),
    .RESET_VEC (PC_W'(RV)),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_ir   (load_ir),
    .load_pc   (load_pc),
    .choose_pc (choose_pc),
    .br_en     (br_en),
    .br_target (br_target),
    .mem       (bus),
    .pc        (pc),
    .ir_valid  (ir_valid),
    .fetch_err (fetch_err),
    .opcode    (opcode),
    .op        (op),
    .rn        (rn),
    .rd        (rd),
    .shift     (shift),
    .rm        (rm),
    .sximm8    (sximm8),
    .sximm5    (sximm5)
  );

  always #5 clk = ~clk;

  // wn = number of wait states before ack, -1 = memory never answers
  typedef struct {
    int addr;
    int data;
    int wn;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pc = RV;
  int   model_ir = 0;
  int   model_err = 0;
  bit   mon_en = 1'b0;
  int   cur_wait = 0;
  int   cur_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference decode written as plain arithmetic on the instruction value.
  task automatic check_fields(input int d);
    int i8;
    int i5;
    i8 = d % 256;
    if (i8 >= 128) i8 = i8 - 256;
    i5 = d % 32;
    if (i5 >= 16) i5 = i5 - 32;
    chk("opcode", int'(opcode), d / 8192);
    chk("op",     int'(op),     (d / 2048) % 4);
    chk("rn",     int'(rn),     (d / 256) % 8);
    chk("rd",     int'(rd),     (d / 32) % 8);
    chk("shift",  int'(shift),  (d / 8) % 4);
    chk("rm",     int'(rm),     d % 8);
    chk("sximm8", int'(sximm8), i8);
    chk("sximm5", int'(sximm5), i5);
  endtask

  // Memory responder: acks after cur_wait request cycles, babbles random
  // acks and data whenever no request is pending.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (cur_wait >= 0 && cnt == cur_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur_data[15:0];
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 16'($urandom);
        end
        cnt++;
      end else begin
        cnt = 0;
        bus.mem_ack   = 1'($urandom % 2);
        bus.mem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: one scoreboard entry per completed request window.
  initial begin
    int   hi;
    bit   prev;
    int   bad_addr;
    exp_t e;
    hi = 0;
    prev = 1'b0;
    bad_addr = -1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = 1'b0;
        hi   = 0;
      end else if (bus.mem_req) begin
        if (!prev) begin
          hi = 0;
          bad_addr = -1;
          chk("ir_valid_cleared_at_start", int'(ir_valid), 0);
        end
        hi++;
        if (sbq.size() > 0 && int'(bus.mem_addr) != sbq[0].addr)
          bad_addr = int'(bus.mem_addr);
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (sbq.size() == 0) begin
          chk("unexpected_fetch", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("mem_addr", (bad_addr < 0) ? e.addr : bad_addr, e.addr);
          chk("req_cycles", hi, (e.wn < 0) ? TIMEOUT + 1 : e.wn + 1);
          if (e.wn < 0) model_err = 1;
          else          model_ir  = e.data;
          chk("ir_valid", int'(ir_valid), (e.wn < 0) ? 0 : 1);
          chk("fetch_err", int'(fetch_err), model_err);
          check_fields(model_ir);
        end
      end
    end
  end

  task automatic step(input bit lir, input bit lp, input bit ch, input bit br,
                      input logic [7:0] tgt);
    chk("pc", int'(pc), model_pc);
    load_ir   = lir;
    load_pc   = lp;
    choose_pc = ch;
    br_en     = br;
    br_target = tgt;
    if (lp) begin
      if (ch)      model_pc = RV;
      else if (br) model_pc = int'(tgt);
      else         model_pc = (model_pc + 1) % 256;
    end
    @(negedge clk);
  endtask

  // pc_mode: 0 no PC traffic, 1 one increment mid-request, 2 random.
  task automatic fetch(input int wn, input int data, input int hold, input int pc_mode);
    exp_t e;
    int   n;
    e.addr = model_pc;
    e.data = data;
    e.wn   = wn;
    sbq.push_back(e);
    cur_wait = wn;
    cur_data = data;
    n = (wn < 0) ? TIMEOUT + 1 : wn + 1;
    for (int i = 0; i < n + 3; i++) begin
      bit         lp;
      bit         ch;
      bit         br;
      logic [7:0] t;
      lp = 1'b0;
      ch = 1'b0;
      br = 1'b0;
      t  = 8'($urandom);
      if (pc_mode == 1) begin
        lp = (i == 1);
      end else if (pc_mode == 2) begin
        lp = ($urandom % 3 == 0);
        ch = ($urandom % 5 == 0);
        br = 1'($urandom % 2);
      end
      step(i < hold, lp, ch, br, t);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wn;
    int hold;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pc",        int'(pc), RV);
    chk("rst_ir_valid",  int'(ir_valid), 0);
    chk("rst_fetch_err", int'(fetch_err), 0);
    chk("rst_mem_req",   int'(bus.mem_req), 0);
    chk("rst_mem_addr",  int'(bus.mem_addr), RV);
    check_fields(0);
    mon_en = 1'b1;

    fetch(0, 16'hD1FF, 1, 0);
    fetch(3, 16'hA2B4, 2, 0);
    fetch(-1, 16'h0000, 1, 0);

    step(0, 1, 0, 1, 8'hFF);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h3C);
    step(0, 1, 1, 1, 8'h77);
    step(0, 0, 0, 0, 8'h00);

    step(0, 1, 0, 1, 8'h05);
    fetch(2, 16'h6A3C, 1, 1);
    fetch(0, 16'h2B17, 1, 0);

    for (int k = 0; k < 40; k++) begin
      wn   = ($urandom % 8 == 0) ? -1 : int'($urandom % 5);
      hold = (wn < 0) ? 1 : 1 + int'($urandom % (wn + 3));
      fetch(wn, int'($urandom % 65536), hold, 2);
    end
    chk("scoreboard_drained", sbq.size(), 0);

    // Asynchronous reset in the middle of a request.
    mon_en = 1'b0;
    step(0, 1, 0, 1, 8'hA5);
    cur_wait = -1;
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    chk("req_before_reset", int'(bus.mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req",   int'(bus.mem_req), 0);
    chk("async_rst_ir_valid",  int'(ir_valid), 0);
    chk("async_rst_pc",        int'(pc), RV);
    chk("async_rst_fetch_err", int'(fetch_err), 0);
    chk("async_rst_mem_addr",  int'(bus.mem_addr), RV);
    chk("async_rst_opcode",    int'(opcode), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
